mux_4_1_rr_sched: RTL and testbench

- Round-robin scheduler that shares one N-bit 4:1 mux path between four requesters and registers the selected word into a valid/ready output stage.
- Sits in front of any single-consumer datapath that is fed by four sources.
- Drives the mux select pair {s0,s1} and returns a per-requester accept pulse.
- Supports bounded bursts, so one owner may hold the path for up to BURST consecutive words.

---
 rtl/mux_sched_pkg.sv | 12 +
 rtl/rr_pick4.sv | 28 ++
 rtl/mux_4_1_rr_sched.sv | 115 +++++++++++
 tb/tb_mux_4_1_rr_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin 4:1 mux scheduler: state encoding
// and the width of a requester index.
package mux_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int IDX_W = 2;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority picker: returns the first set request
// found when scanning upward from 'start', wrapping past index 3.
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [3:0]       req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the far end back toward 'start' so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = start + IDX_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux between four requesters, with
// bounded bursts and a single-register valid/ready output stage.
module mux_4_1_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [N-1:0] i0,
    input  logic [N-1:0] i1,
    input  logic [N-1:0] i2,
    input  logic [N-1:0] i3,
    output logic [3:0]   gnt,
    output logic         s0,
    output logic         s1,
    output logic [N-1:0] out,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [7:0] BURST_C = 8'(BURST);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [N-1:0]     out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic             busy, load_ok, rel, arb, cont, found;
    logic [IDX_W-1:0] start, win, sel;
    logic [3:0]       gnt_c;
    logic [N-1:0]     mux_word;

    assign busy    = (state_q == ST_BUSY);
    assign load_ok = !out_valid_q || out_ready;
    assign rel     = busy && (!req[owner_q] || cnt_q == BURST_C);
    // Reset gates the Mealy outputs so nothing is granted while rst is high.
    assign arb     = !rst && load_ok && (!busy || rel);
    assign cont    = !rst && load_ok && busy && !rel;
    assign start   = busy ? owner_q + 2'd1 : last_q + 2'd1;

    rr_pick4 u_pick (
        .req   (req),
        .start (start),
        .found (found),
        .idx   (win)
    );

    always_comb begin
        sel         = owner_q;
        gnt_c       = '0;
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        if (arb) begin
            if (busy) last_d = owner_q;
            if (found) begin
                sel         = win;
                gnt_c[win]  = 1'b1;
                owner_d     = win;
                cnt_d       = 8'd1;
                state_d     = ST_BUSY;
                out_valid_d = 1'b1;
            end else begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        end else if (cont) begin
            gnt_c[owner_q] = 1'b1;
            cnt_d          = cnt_q + 8'd1;
            out_valid_d    = 1'b1;
        end
    end

    always_comb begin
        case (sel)
            2'd0:    mux_word = i0;
            2'd1:    mux_word = i1;
            2'd2:    mux_word = i2;
            default: mux_word = i3;
        endcase
        out_d = (|gnt_c) ? mux_word : out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            last_q      <= 2'd3;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gnt       = gnt_c;
    assign s0        = sel[1];
    assign s1        = sel[0];
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_4_1_rr_sched.sv
// Bench for mux_4_1_rr_sched: two instances (BURST=4 and BURST=2) checked
// against a cycle-level reference model, plus directed corner sequences.
module tb_mux_4_1_rr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0;
    logic       out_ready = 1'b0;

    logic [3:0] gnt_a, gnt_b, out_a, out_b;
    logic       s0_a, s1_a, s0_b, s1_b, valid_a, valid_b;

    logic [3:0] pk_req;
    logic [1:0] pk_start, pk_idx;
    logic       pk_found;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, one slot per instance.
    int m_burst [2] = '{4, 2};
    int m_busy  [2];
    int m_owner [2];
    int m_taken [2];
    int m_last  [2];
    int m_out   [2];
    int m_valid [2];
    int m_sel   [2];

    logic [3:0] seen_gnt_a, seen_gnt_b, seen_out_a;
    logic [1:0] seen_sel_a;
    logic       seen_valid_a, seen_valid_b;

    typedef struct {
        logic [3:0] req;
        logic [1:0] start;
        logic       found;
        logic [1:0] idx;
    } pick_vec_t;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
    } rr_vec_t;

    always #5 clk = ~clk;

    mux_4_1_rr_sched #(.N(4), .BURST(4)) dut_a (
        .clk(clk), .rst(rst), .req(req), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .gnt(gnt_a), .s0(s0_a), .s1(s1_a), .out(out_a), .out_valid(valid_a),
        .out_ready(out_ready)
    );

    mux_4_1_rr_sched #(.N(4), .BURST(2)) dut_b (
        .clk(clk), .rst(rst), .req(req), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .gnt(gnt_b), .s0(s0_b), .s1(s1_b), .out(out_b), .out_valid(valid_b),
        .out_ready(out_ready)
    );

    rr_pick4 u_pick (
        .req(pk_req), .start(pk_start), .found(pk_found), .idx(pk_idx)
    );

    task automatic cmp(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d]  = 0;
            m_owner[d] = 0;
            m_taken[d] = 0;
            m_last[d]  = 3;
            m_out[d]   = 0;
            m_valid[d] = 0;
            m_sel[d]   = 0;
        end
    endtask

    // Samples both instances mid-cycle, compares against the model, then
    // advances the model by one clock and returns just after the next edge.
    task automatic checkOutput();
        int dat [4];
        int lok, start, win, eg, es;
        int act_gnt, act_sel, act_out, act_val;
        @(negedge clk);
        dat[0] = int'(i0); dat[1] = int'(i1); dat[2] = int'(i2); dat[3] = int'(i3);
        seen_gnt_a = gnt_a; seen_gnt_b = gnt_b; seen_sel_a = {s0_a, s1_a};
        seen_out_a = out_a; seen_valid_a = valid_a; seen_valid_b = valid_b;
        for (int d = 0; d < 2; d++) begin
            act_gnt = (d == 0) ? int'(gnt_a) : int'(gnt_b);
            act_sel = (d == 0) ? int'({s0_a, s1_a}) : int'({s0_b, s1_b});
            act_out = (d == 0) ? int'(out_a) : int'(out_b);
            act_val = (d == 0) ? int'(valid_a) : int'(valid_b);
            cmp((d == 0) ? "out_a" : "out_b", act_out, m_out[d]);
            cmp((d == 0) ? "valid_a" : "valid_b", act_val, m_valid[d]);
            eg  = 0;
            es  = m_sel[d];
            lok = (m_valid[d] == 0 || out_ready) ? 1 : 0;
            if (lok != 0) begin
                if (m_busy[d] != 0 && req[m_owner[d]] && m_taken[d] < m_burst[d]) begin
                    eg = 1 << m_owner[d];
                    m_out[d] = dat[m_owner[d]];
                    m_taken[d]++;
                    m_valid[d] = 1;
                end else begin
                    start = (m_busy[d] != 0) ? m_owner[d] + 1 : m_last[d] + 1;
                    if (m_busy[d] != 0) m_last[d] = m_owner[d];
                    win = -1;
                    for (int k = 0; k < 4; k++)
                        if (win < 0 && req[(start + k) % 4]) win = (start + k) % 4;
                    if (win >= 0) begin
                        eg = 1 << win;
                        es = win;
                        m_out[d]   = dat[win];
                        m_valid[d] = 1;
                        m_owner[d] = win;
                        m_taken[d] = 1;
                        m_busy[d]  = 1;
                    end else begin
                        m_busy[d]  = 0;
                        m_valid[d] = 0;
                    end
                end
            end
            cmp((d == 0) ? "gnt_a" : "gnt_b", act_gnt, eg);
            cmp((d == 0) ? "sel_a" : "sel_b", act_sel, es);
            m_sel[d] = es;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rdy,
                                 input logic [3:0] d0, input logic [3:0] d1,
                                 input logic [3:0] d2, input logic [3:0] d3);
        req = r; out_ready = rdy;
        i0 = d0; i1 = d1; i2 = d2; i3 = d3;
        checkOutput();
    endtask

    task automatic doReset();
        rst = 1'b1; req = '0; out_ready = 1'b0;
        #1;
        cmp("rst_out", int'(out_a), 0);
        cmp("rst_valid", int'(valid_a), 0);
        cmp("rst_gnt", int'(gnt_a), 0);
        cmp("rst_sel", int'({s0_a, s1_a}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired after %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        pick_vec_t pick_tab [9];
        rr_vec_t   rr_tab [17];
        logic [3:0] d0;

        pick_tab[0] = '{4'b0000, 2'd0, 1'b0, 2'd0};
        pick_tab[1] = '{4'b0001, 2'd0, 1'b1, 2'd0};
        pick_tab[2] = '{4'b0001, 2'd1, 1'b1, 2'd0};
        pick_tab[3] = '{4'b1010, 2'd0, 1'b1, 2'd1};
        pick_tab[4] = '{4'b1010, 2'd2, 1'b1, 2'd3};
        pick_tab[5] = '{4'b1010, 2'd3, 1'b1, 2'd3};
        pick_tab[6] = '{4'b0110, 2'd3, 1'b1, 2'd1};
        pick_tab[7] = '{4'b1000, 2'd1, 1'b1, 2'd3};
        pick_tab[8] = '{4'b0101, 2'd1, 1'b1, 2'd2};
        for (int c = 0; c < 17; c++)
            rr_tab[c] = '{4'b1111, 1'b1, 4'(1 << ((c / 4) % 4)), 2'((c / 4) % 4)};

        modelReset();

        // Picker truth table.
        for (int v = 0; v < 9; v++) begin
            pk_req = pick_tab[v].req; pk_start = pick_tab[v].start;
            #1;
            cmp("pick_found", int'(pk_found), int'(pick_tab[v].found));
            if (pick_tab[v].found) cmp("pick_idx", int'(pk_idx), int'(pick_tab[v].idx));
        end

        // Full contention: four-word bursts rotating 0,1,2,3 then back to 0.
        doReset();
        for (int c = 0; c < 17; c++) begin
            applyStimulus(rr_tab[c].req, rr_tab[c].rdy, 4'd1, 4'd2, 4'd3, 4'd4);
            cmp("rr_gnt", int'(seen_gnt_a), int'(rr_tab[c].gnt));
            cmp("rr_sel", int'(seen_sel_a), int'(rr_tab[c].sel));
        end

        // Backpressure on a single requester that advances its data on grant.
        doReset();
        d0 = 4'd1;
        applyStimulus(4'b0001, 1'b1, d0, 4'd0, 4'd0, 4'd0);
        cmp("bp_first_gnt", int'(seen_gnt_a), 1);
        d0 = d0 + 4'd1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0001, 1'b0, d0, 4'd0, 4'd0, 4'd0);
            cmp("bp_stall_gnt", int'(seen_gnt_a), 0);
            cmp("bp_stall_out", int'(seen_out_a), 1);
            cmp("bp_stall_valid", int'(seen_valid_a), 1);
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0001, 1'b1, d0, 4'd0, 4'd0, 4'd0);
            cmp("bp_resume_gnt", int'(seen_gnt_a), 1);
            d0 = d0 + 4'd1;
        end

        // Early release: requester 2 drops after two words, 3 follows at once.
        doReset();
        applyStimulus(4'b1100, 1'b1, 4'd0, 4'd0, 4'd9, 4'd5);
        cmp("er_gnt0", int'(seen_gnt_a), 4);
        applyStimulus(4'b1100, 1'b1, 4'd0, 4'd0, 4'd9, 4'd5);
        cmp("er_gnt1", int'(seen_gnt_a), 4);
        cmp("er_out1", int'(seen_out_a), 9);
        applyStimulus(4'b1000, 1'b1, 4'd0, 4'd0, 4'd9, 4'd5);
        cmp("er_gnt2", int'(seen_gnt_a), 8);
        cmp("er_out2", int'(seen_out_a), 9);
        applyStimulus(4'b1000, 1'b1, 4'd0, 4'd0, 4'd9, 4'd5);
        cmp("er_out3", int'(seen_out_a), 5);
        cmp("er_valid3", int'(seen_valid_a), 1);

        // Lone requester on the BURST=2 instance is re-granted without bubbles.
        doReset();
        for (int c = 0; c < 7; c++) begin
            applyStimulus(4'b0010, 1'b1, 4'd0, 4'(c), 4'd0, 4'd0);
            cmp("lone_gnt_b", int'(seen_gnt_b), 2);
            if (c > 0) cmp("lone_valid_b", int'(seen_valid_b), 1);
        end

        // Asynchronous reset in the middle of a burst.
        doReset();
        applyStimulus(4'b1111, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        applyStimulus(4'b1111, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        #2;
        rst = 1'b1; req = 4'b1000;
        #1;
        cmp("mid_rst_out", int'(out_a), 0);
        cmp("mid_rst_valid", int'(valid_a), 0);
        cmp("mid_rst_gnt", int'(gnt_a), 0);
        cmp("mid_rst_sel", int'({s0_a, s1_a}), 0);
        cmp("mid_rst_gnt_b", int'(gnt_b), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        applyStimulus(4'b1000, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        cmp("post_rst_gnt", int'(seen_gnt_a), 8);
        cmp("post_rst_sel", int'(seen_sel_a), 3);

        // Idle drain: select keeps pointing at the last owner.
        doReset();
        applyStimulus(4'b0100, 1'b1, 4'd0, 4'd0, 4'd7, 4'd0);
        applyStimulus(4'b0000, 1'b1, 4'd0, 4'd0, 4'd7, 4'd0);
        cmp("drain_gnt", int'(seen_gnt_a), 0);
        cmp("drain_sel", int'(seen_sel_a), 2);
        cmp("drain_valid_hold", int'(seen_valid_a), 1);
        applyStimulus(4'b0000, 1'b1, 4'd0, 4'd0, 4'd7, 4'd0);
        cmp("drain_valid_fall", int'(seen_valid_a), 0);
        cmp("drain_sel_hold", int'(seen_sel_a), 2);

        // Randomised traffic with backpressure, checked by the model only.
        doReset();
        for (int c = 0; c < 500; c++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) r = '0;
            applyStimulus(r, ($urandom_range(0, 3) != 0),
                          4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
